dr_fetch_sequencer: RTL
=======================

Name: dr_fetch_sequencer

Overview:
- Byte-serial fetch controller directly upstream of the 32-bit data register (DR).
- Reads 1-4 consecutive bytes from byte-wide memory over a request/valid handshake.
- Feeds each byte to the DR and drives the DR's E/FunSel controls so the DR ends holding the assembled word, zero- or sign-extended, in big- or little-endian order.
- Sits between the memory port and the DR in the datapath; started by the control unit.

Parameters:
- ADDR_W, 16, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- TIMEOUT, 15, max cycles MemRd may stay high without MemValid before aborting with Err.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- Start  input  1  begin fetch; sampled only in IDLE
- Addr  input  ADDR_W  base (lowest) byte address, latched on accepted Start
- Count  input  3  bytes to fetch, legal 1..4, latched on accepted Start
- Endian  input  1  0 = little-endian (byte at Addr is LSB), 1 = big-endian (byte at Addr is MSB)
- SignExt  input  1  1 = sign-extend from the MSB of the most-significant fetched byte, 0 = zero-extend
- MemAddr  output  ADDR_W  byte address of current request
- MemRd  output  1  read request, held until MemValid
- MemData  input  8  read data, valid when MemValid=1
- MemValid  input  1  read complete; honoured only while MemRd=1
- DR_E  output  1  DR enable, one-cycle pulse per byte
- DR_FunSel  output  2  DR function: 00 load sign-extended, 01 load zero-extended, 10 shift left and insert byte
- DR_In  output  8  byte presented to the DR
- Busy  output  1  high from the cycle after Start is accepted until Done
- Done  output  1  one-cycle completion pulse
- Err  output  1  valid with Done; 1 = illegal Count or timeout

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; MemAddr, MemRd, DR_E, DR_FunSel, DR_In, Busy, Done, Err all 0; byte index and timeout counter cleared. Takes priority over everything, including mid-fetch; a partial DR assembly is abandoned.
- States:
  - IDLE: on Start=1, latch Addr/Count/Endian/SignExt, set index i=0, go to REQ. If Count is 0 or >4, go to DONE with Err=1 instead.
  - REQ: MemRd=1 and MemAddr held stable. On MemValid=1, capture MemData and go to WRITE. If the wait counter reaches TIMEOUT, go to DONE with Err=1; no further DR writes occur.
  - WRITE: DR_E=1 and DR_In=captured byte for exactly one cycle. Increment i; go to REQ if i+1<Count, else go to DONE.
  - DONE: Done=1 for one cycle, Busy=0, Err per cause; then go to IDLE.
- Fetch order (most-significant byte first, so the DR always shifts left):
  - Big-endian: address for index i is Addr+i.
  - Little-endian: address for index i is Addr+Count-1-i.
  - Addresses wrap modulo 2^ADDR_W.
- FunSel rules:
  - i=0: 00 if SignExt=1, else 01.
  - i>0: 10.
  - Result is a Count-byte value extended to 32 bits. FunSel 11 is never driven.
- Timing with zero-wait memory (MemValid high in the first REQ cycle), Start sampled at edge t:
  - MemRd high at t+1.
  - DR_E for byte i at t+2+2i.
  - Done at t+2·Count+1.
  - Next Start is accepted in IDLE at t+2·Count+2.
- Each REQ cycle without MemValid adds one cycle. The wait counter resets on entry to each REQ.
- Start is ignored outside IDLE; Start and Done coinciding does not retrigger.
- MemValid outside REQ is ignored.
- Outputs are registered; DR_In holds its last value when DR_E=0.

Test Plan:
- Big-endian, zero-wait memory: Addr=0x0010, Count=4, SignExt=0, Endian=1, mem[0x10..0x13]=12,34,56,78 -> DR_E pulses at t+2,4,6,8 with FunSel 01,10,10,10; DR=0x12345678; Done at t+9, Err=0.
- Little-endian sign-extend: Addr=0x0020, Count=2, Endian=0, SignExt=1, mem[0x20]=0x34, mem[0x21]=0xF2 -> reads 0x21 then 0x20; DR=0xFFFFF234.
- Wait states: same as the first case but MemValid delayed 3 cycles per byte -> MemRd/MemAddr held stable while waiting; Done at t+21; DR=0x12345678.
- Illegal Count=0 and Count=5 -> no MemRd, no DR_E; Done with Err=1 at t+1.
- Timeout plus wrap: Addr=0xFFFF, Count=2, Endian=1, valid only for 0xFFFF -> second request targets address 0x0000; after TIMEOUT cycles Done with Err=1; only 1 DR_E seen.
- Reset mid-fetch after byte 1, then a new Start -> all outputs 0 the next cycle; new fetch completes normally; Start pulses while Busy are ignored.

Source files
------------

// File: rtl/dr_fetch_sequencer_if.sv
// Byte-wide memory read port between the DR fetch sequencer (master) and memory (slave).
interface dr_fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRd;
    logic [7:0]        MemData;
    logic              MemValid;

    modport master (
        output MemAddr,
        output MemRd,
        input  MemData,
        input  MemValid
    );

    modport slave (
        input  MemAddr,
        input  MemRd,
        output MemData,
        output MemValid
    );
endinterface

// File: rtl/dr_fetch_sequencer.sv
// Fetches 1-4 bytes most-significant first and drives the DR load/shift controls so the
// DR ends holding the assembled, zero- or sign-extended word. All outputs are registered.
module dr_fetch_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 Start,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic [2:0]           Count,
    input  logic                 Endian,
    input  logic                 SignExt,
    dr_fetch_sequencer_if.master mem,
    output logic                 DR_E,
    output logic [1:0]           DR_FunSel,
    output logic [7:0]           DR_In,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [1:0]        state_q,  state_d;
    logic [1:0]        idx_q,    idx_d;
    logic [2:0]        count_q,  count_d;
    logic              endian_q, endian_d;
    logic              sext_q,   sext_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [WAIT_W-1:0] wait_q,   wait_d;
    logic              mem_rd_q, mem_rd_d;
    logic              dr_e_q,   dr_e_d;
    logic [1:0]        funsel_q, funsel_d;
    logic [7:0]        dr_in_q,  dr_in_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        endian_d = endian_q;
        sext_d   = sext_q;
        addr_d   = addr_q;
        wait_d   = wait_q;
        mem_rd_d = 1'b0;
        dr_e_d   = 1'b0;
        funsel_d = funsel_q;
        dr_in_d  = dr_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    count_d  = Count;
                    endian_d = Endian;
                    sext_d   = SignExt;
                    idx_d    = 2'd0;
                    wait_d   = '0;
                    if (Count == 3'd0 || Count > 3'd4) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        // MSB first: little-endian starts at the top byte and walks down.
                        state_d  = S_REQ;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                        addr_d   = Endian ? Addr : Addr + ADDR_W'(Count - 3'd1);
                    end
                end
            end
            S_REQ: begin
                if (mem.MemValid) begin
                    state_d  = S_WRITE;
                    dr_e_d   = 1'b1;
                    dr_in_d  = mem.MemData;
                    funsel_d = (idx_q == 2'd0) ? (sext_q ? 2'b00 : 2'b01) : 2'b10;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d   = wait_q + 1'b1;
                    mem_rd_d = 1'b1;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 2'd1;
                if (({1'b0, idx_q} + 3'd1) < count_q) begin
                    state_d  = S_REQ;
                    mem_rd_d = 1'b1;
                    wait_d   = '0;
                    addr_d   = endian_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                // DONE ignores Start so a Start coinciding with Done cannot retrigger.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            count_q  <= 3'd0;
            endian_q <= 1'b0;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wait_q   <= '0;
            mem_rd_q <= 1'b0;
            dr_e_q   <= 1'b0;
            funsel_q <= 2'b00;
            dr_in_q  <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            endian_q <= endian_d;
            sext_q   <= sext_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            mem_rd_q <= mem_rd_d;
            dr_e_q   <= dr_e_d;
            funsel_q <= funsel_d;
            dr_in_q  <= dr_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign mem.MemAddr = addr_q;
    assign mem.MemRd   = mem_rd_q;
    assign DR_E        = dr_e_q;
    assign DR_FunSel   = funsel_q;
    assign DR_In       = dr_in_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Err         = err_q;
endmodule
